// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for mem_arbiter
//
// Contents:
//   DEF_ADDR_W, DEF_DATA_W : default address/data widths
//   state_e                : arbiter FSM states (IDLE, REQ, WAIT)
//   owner_e                : owner of the outstanding transaction (OWN_IF, OWN_LS)
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - combinational grant between fetch and load/store requesters
//
// Ports:
//   i_if_valid    : fetch requester has a request
//   i_ls_valid    : load/store requester has a request
//   i_last_if     : 1 when the previous grant went to fetch (MEM_ARB_RR_EN builds only)
//   o_grant_valid : at least one requester is asking
//   o_owner       : requester that wins this cycle (meaningful when o_grant_valid)
//
// Configuration macro: MEM_ARB_RR_EN selects round-robin; otherwise load/store has
// fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic   i_if_valid,
  input  logic   i_ls_valid,
`ifdef MEM_ARB_RR_EN
  input  logic   i_last_if,
`endif
  output logic   o_grant_valid,
  output owner_e o_owner
);

  logic w_pick_ls;

`ifdef MEM_ARB_RR_EN
  // On contention the requester that did not win last time goes first.
  assign w_pick_ls = i_ls_valid & (~i_if_valid | i_last_if);
`else
  assign w_pick_ls = i_ls_valid;
`endif

  assign o_grant_valid = i_if_valid | i_ls_valid;
  assign o_owner       = w_pick_ls ? OWN_LS : OWN_IF;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter onto one shared memory port
//
// Ports:
//   i_clk, i_rst_n                      : clock, asynchronous active-low reset
//   i_if_req_valid / o_if_req_ready     : fetch request handshake, i_if_addr address
//   o_if_resp_valid / o_if_rdata        : fetch response pulse and data
//   i_ls_req_valid / o_ls_req_ready     : load/store request handshake
//   i_ls_addr, i_ls_wen, i_ls_wdata, i_ls_wmask : load/store request fields
//   o_ls_resp_valid / o_ls_rdata        : load/store response pulse and data (0 for stores)
//   o_mem_req_valid / i_mem_req_ready   : shared memory request handshake
//   o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask : latched request fields
//   i_mem_resp_valid / i_mem_rdata      : memory response
//
// Configuration macro: MEM_ARB_RR_EN enables round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req_valid,
  output logic                o_if_req_ready,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_resp_valid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req_valid,
  output logic                o_ls_req_ready,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic                i_ls_wen,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_wmask,
  output logic                o_ls_resp_valid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_resp_valid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;

  logic [1:0]        r_state;
  owner_e            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic              r_if_resp_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_ls_resp_valid;
  logic [DATA_W-1:0] r_ls_rdata;

  logic              w_idle;
  logic              w_grant_valid;
  owner_e            w_grant_owner;
  logic              w_if_ready;
  logic              w_ls_ready;
  logic              w_accept;
  logic              w_pick_ls;

`ifdef MEM_ARB_RR_EN
  logic              r_last_if;
`endif

  assign w_idle = (r_state == S_IDLE);

  mem_arb_grant u_grant (
    .i_if_valid    (i_if_req_valid),
    .i_ls_valid    (i_ls_req_valid),
`ifdef MEM_ARB_RR_EN
    .i_last_if     (r_last_if),
`endif
    .o_grant_valid (w_grant_valid),
    .o_owner       (w_grant_owner)
  );

  // Ready is only offered while no transaction is outstanding, so a requester
  // never sees ready during REQ/WAIT even if it is the "winner".
  assign w_pick_ls  = (w_grant_owner == OWN_LS);
  assign w_if_ready = w_idle & w_grant_valid & ~w_pick_ls;
  assign w_ls_ready = w_idle & w_grant_valid &  w_pick_ls;
  assign w_accept   = w_if_ready | w_ls_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_owner         <= OWN_IF;
      r_addr          <= '0;
      r_wen           <= 1'b0;
      r_wdata         <= '0;
      r_wmask         <= '0;
      r_if_resp_valid <= 1'b0;
      r_if_rdata      <= '0;
      r_ls_resp_valid <= 1'b0;
      r_ls_rdata      <= '0;
    end else begin
      // Response strobes are single-cycle pulses.
      r_if_resp_valid <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner <= w_grant_owner;
            r_addr  <= w_pick_ls ? i_ls_addr : i_if_addr;
            // Fetches are always plain reads with no payload.
            r_wen   <= w_pick_ls & i_ls_wen;
            r_wdata <= w_pick_ls ? i_ls_wdata : '0;
            r_wmask <= w_pick_ls ? i_ls_wmask : '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_mem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_mem_resp_valid) begin
            if (r_owner == OWN_LS) begin
              r_ls_resp_valid <= 1'b1;
              // A store completion carries no data back.
              r_ls_rdata      <= r_wen ? '0 : i_mem_rdata;
            end else begin
              r_if_resp_valid <= 1'b1;
              r_if_rdata      <= i_mem_rdata;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  // Reset value "last grant was fetch" makes load/store win the first contention.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_if <= 1'b1;
    end else if (w_accept) begin
      r_last_if <= ~w_pick_ls;
    end
  end
`endif

  assign o_if_req_ready  = w_if_ready;
  assign o_ls_req_ready  = w_ls_ready;
  assign o_if_resp_valid = r_if_resp_valid;
  assign o_if_rdata      = r_if_rdata;
  assign o_ls_resp_valid = r_ls_resp_valid;
  assign o_ls_rdata      = r_ls_rdata;
  assign o_mem_req_valid = (r_state == S_REQ);
  assign o_mem_addr      = r_addr;
  assign o_mem_wen       = r_wen;
  assign o_mem_wdata     = r_wdata;
  assign o_mem_wmask     = r_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_v, if_rdy, if_resp;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_v, ls_rdy, ls_wen, ls_resp;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [MW-1:0] ls_wmask;
  logic          mem_v, mem_rdy, mem_wen, mem_rsp;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req_valid(if_v), .o_if_req_ready(if_rdy), .i_if_addr(if_addr),
    .o_if_resp_valid(if_resp), .o_if_rdata(if_rdata),
    .i_ls_req_valid(ls_v), .o_ls_req_ready(ls_rdy), .i_ls_addr(ls_addr),
    .i_ls_wen(ls_wen), .i_ls_wdata(ls_wdata), .i_ls_wmask(ls_wmask),
    .o_ls_resp_valid(ls_resp), .o_ls_rdata(ls_rdata),
    .o_mem_req_valid(mem_v), .i_mem_req_ready(mem_rdy),
    .o_mem_addr(mem_addr), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata),
    .o_mem_wmask(mem_wmask), .i_mem_resp_valid(mem_rsp), .i_mem_rdata(mem_rdata)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_v = 0; if_addr = '0; ls_v = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0;
    ls_wmask = '0; mem_rdy = 0; mem_rsp = 0; mem_rdata = '0;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_if_rdy"}, if_rdy, 0);       chk({p, "_ls_rdy"}, ls_rdy, 0);
    chk({p, "_if_resp"}, if_resp, 0);     chk({p, "_if_rdata"}, if_rdata, 0);
    chk({p, "_ls_resp"}, ls_resp, 0);     chk({p, "_ls_rdata"}, ls_rdata, 0);
    chk({p, "_mem_v"}, mem_v, 0);         chk({p, "_mem_addr"}, mem_addr, 0);
    chk({p, "_mem_wen"}, mem_wen, 0);     chk({p, "_mem_wdata"}, mem_wdata, 0);
    chk({p, "_mem_wmask"}, 64'(mem_wmask), 0);
  endtask

  // Leaves the bench at posedge+1 with reset released: a request may be accepted now.
  task automatic do_reset(input bit check_outputs);
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    if (check_outputs) check_zero("rst");
    next_cyc();
    rst_n = 1;
  endtask

  typedef struct {
    logic if_v;
    logic ls_v;
    logic exp_if;
    logic exp_ls;
  } gvec_t;

  // Reference model state (transaction level).
  bit            m_busy, m_issued, p_ls, p_wen;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [MW-1:0] p_wmask;
  bit            e_if_pulse, e_ls_pulse;
  logic [DW-1:0] e_if_rdata, e_ls_rdata;
`ifdef MEM_ARB_RR_EN
  bit            m_last_if;
`endif

  task automatic model_reset();
    m_busy = 0; m_issued = 0; e_if_pulse = 0; e_ls_pulse = 0;
    e_if_rdata = '0; e_ls_rdata = '0;
`ifdef MEM_ARB_RR_EN
    m_last_if = 1;
`endif
  endtask

  initial begin
    gvec_t vt[4];
    bit    grants[4];
    int    ng;
    bit    g_if, g_ls;
    logic [DW-1:0] rd;

    clear_inputs();
    do_reset(1);

    // Grant table from IDLE; valids drop before the edge so nothing is accepted.
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      if_v = vt[i].if_v; ls_v = vt[i].ls_v;
      @(negedge clk);
      chk($sformatf("vec%0d_if_rdy", i), if_rdy, vt[i].exp_if);
      chk($sformatf("vec%0d_ls_rdy", i), ls_rdy, vt[i].exp_ls);
      if_v = 0; ls_v = 0;
      next_cyc();
    end

    // Fetch with minimum latency.
    if_v = 1; if_addr = 64'h8000_0000;
    @(negedge clk); chk("f_acc_rdy", if_rdy, 1); chk("f_acc_ls_rdy", ls_rdy, 0);
    next_cyc(); if_v = 0; if_addr = '1; mem_rdy = 1;
    @(negedge clk);
    chk("f_mem_v", mem_v, 1); chk("f_mem_addr", mem_addr, 64'h8000_0000);
    chk("f_mem_wen", mem_wen, 0); chk("f_mem_wdata", mem_wdata, 0);
    chk("f_mem_wmask", 64'(mem_wmask), 0);
    next_cyc(); mem_rdy = 0; mem_rsp = 1; mem_rdata = 64'h00100073_00000413;
    @(negedge clk); chk("f_wait_nopulse", if_resp, 0); chk("f_wait_mem_v", mem_v, 0);
    next_cyc(); mem_rsp = 0;
    @(negedge clk);
    chk("f_pulse", if_resp, 1); chk("f_rdata", if_rdata, 64'h00100073_00000413);
    chk("f_ls_quiet", ls_resp, 0);
    next_cyc();
    @(negedge clk); chk("f_pulse_once", if_resp, 0);

    // Store stalled by memory for four cycles.
    next_cyc();
    ls_v = 1; ls_wen = 1; ls_addr = 64'h8000_1000; ls_wdata = 64'h87654321_12345678;
    ls_wmask = 8'h03;
    @(negedge clk); chk("s_acc_rdy", ls_rdy, 1);
    next_cyc(); ls_v = 0; ls_addr = '1; ls_wdata = '0; ls_wmask = '1; ls_wen = 0;
    for (int i = 0; i < 5; i++) begin
      mem_rdy = (i == 4);
      @(negedge clk);
      chk($sformatf("s_mem_v%0d", i), mem_v, 1);
      chk($sformatf("s_addr%0d", i), mem_addr, 64'h8000_1000);
      chk($sformatf("s_wen%0d", i), mem_wen, 1);
      chk($sformatf("s_wdata%0d", i), mem_wdata, 64'h87654321_12345678);
      chk($sformatf("s_wmask%0d", i), 64'(mem_wmask), 64'h03);
      next_cyc();
    end
    mem_rdy = 0; mem_rsp = 1; mem_rdata = 64'hdead_beef_cafe_f00d;
    @(negedge clk); chk("s_wait_nopulse", ls_resp, 0);
    next_cyc(); mem_rsp = 0;
    @(negedge clk);
    chk("s_pulse", ls_resp, 1); chk("s_rdata_zero", ls_rdata, 0);
    chk("s_if_quiet", if_resp, 0); chk("s_if_rdata_held", if_rdata, 64'h00100073_00000413);

    // Continuous contention for four transactions.
    do_reset(0);
    if_v = 1; ls_v = 1; mem_rdy = 1; mem_rsp = 1; mem_rdata = 64'h1234;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (ls_rdy) begin grants[ng] = 1; ng++; end
      else if (if_rdy) begin grants[ng] = 0; ng++; end
      next_cyc();
    end
    chk("prio_count", 64'(ng), 4);
    for (int k = 0; k < ng; k++) begin
`ifdef MEM_ARB_RR_EN
      chk($sformatf("prio_grant%0d_is_ls", k), grants[k], (k % 2 == 0));
`else
      chk($sformatf("prio_grant%0d_is_ls", k), grants[k], 1);
`endif
    end

    // Reset while waiting for the memory response.
    do_reset(0);
    if_v = 1; if_addr = 64'h8000_2000;
    @(negedge clk); next_cyc(); if_v = 0; mem_rdy = 1;
    @(negedge clk); next_cyc(); mem_rdy = 0;
    @(negedge clk);
    rst_n = 0; #1;
    check_zero("rw");
    mem_rsp = 1; mem_rdata = 64'h5555_aaaa_5555_aaaa;
    next_cyc(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rw_if_resp%0d", i), if_resp, 0);
      chk($sformatf("rw_ls_resp%0d", i), ls_resp, 0);
      chk($sformatf("rw_mem_v%0d", i), mem_v, 0);
      chk($sformatf("rw_if_rdata%0d", i), if_rdata, 0);
      next_cyc();
    end
    mem_rsp = 0; if_v = 1;
    @(negedge clk); chk("rw_idle_rdy", if_rdy, 1);
    if_v = 0;
    next_cyc();

    // Spurious memory strobes outside their states.
    do_reset(0);
    mem_rsp = 1; mem_rdata = 64'h0bad;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("sp_idle_if_resp%0d", i), if_resp, 0);
      chk($sformatf("sp_idle_ls_resp%0d", i), ls_resp, 0);
      chk($sformatf("sp_idle_mem_v%0d", i), mem_v, 0);
      next_cyc();
    end
    mem_rsp = 0; if_v = 1; if_addr = 64'h8000_3000;
    @(negedge clk); next_cyc(); if_v = 0; mem_rdy = 1;
    @(negedge clk); next_cyc(); if_v = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("sp_wait_mem_v%0d", i), mem_v, 0);
      chk($sformatf("sp_wait_if_resp%0d", i), if_resp, 0);
      chk($sformatf("sp_wait_if_rdy%0d", i), if_rdy, 0);
      next_cyc();
    end
    if_v = 0; mem_rdy = 0; mem_rsp = 1; mem_rdata = 64'h7777_0000_7777;
    @(negedge clk); chk("sp_resp_early", if_resp, 0);
    next_cyc(); mem_rsp = 0;
    @(negedge clk); chk("sp_resp", if_resp, 1); chk("sp_rdata", if_rdata, 64'h7777_0000_7777);
    next_cyc();

    // Randomized traffic against the transaction-level model.
    do_reset(0);
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 99) == 0) begin
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        check_zero("rnd_rst");
        next_cyc();
        rst_n = 1;
        model_reset();
        continue;
      end
      if_v = ($urandom_range(0, 2) != 0); ls_v = ($urandom_range(0, 2) != 0);
      if_addr = {$urandom, $urandom}; ls_addr = {$urandom, $urandom};
      ls_wen = $urandom_range(0, 1); ls_wdata = {$urandom, $urandom};
      ls_wmask = MW'($urandom);
      mem_rdy = ($urandom_range(0, 2) != 0); mem_rsp = ($urandom_range(0, 2) != 0);
      rd = {$urandom, $urandom}; mem_rdata = rd;
      @(negedge clk);

      g_if = 0; g_ls = 0;
      if (!m_busy) begin
        if (if_v && ls_v) begin
`ifdef MEM_ARB_RR_EN
          g_ls = m_last_if; g_if = !m_last_if;
`else
          g_ls = 1;
`endif
        end else begin
          g_if = if_v; g_ls = ls_v;
        end
      end
      chk("rnd_if_rdy", if_rdy, g_if);
      chk("rnd_ls_rdy", ls_rdy, g_ls);
      chk("rnd_mem_v", mem_v, m_busy && !m_issued);
      if (m_busy && !m_issued) begin
        chk("rnd_mem_addr", mem_addr, p_addr);
        chk("rnd_mem_wen", mem_wen, p_wen);
        chk("rnd_mem_wdata", mem_wdata, p_wdata);
        chk("rnd_mem_wmask", 64'(mem_wmask), 64'(p_wmask));
      end
      chk("rnd_if_resp", if_resp, e_if_pulse);
      chk("rnd_ls_resp", ls_resp, e_ls_pulse);
      chk("rnd_if_rdata", if_rdata, e_if_rdata);
      chk("rnd_ls_rdata", ls_rdata, e_ls_rdata);

      e_if_pulse = 0; e_ls_pulse = 0;
      if (!m_busy) begin
        if (g_if || g_ls) begin
          m_busy = 1; m_issued = 0; p_ls = g_ls;
          p_addr  = g_ls ? ls_addr : if_addr;
          p_wen   = g_ls && ls_wen;
          p_wdata = g_ls ? ls_wdata : '0;
          p_wmask = g_ls ? ls_wmask : '0;
`ifdef MEM_ARB_RR_EN
          m_last_if = g_if;
`endif
        end
      end else if (!m_issued) begin
        if (mem_rdy) m_issued = 1;
      end else if (mem_rsp) begin
        m_busy = 0;
        if (p_ls) begin
          e_ls_pulse = 1; e_ls_rdata = p_wen ? '0 : rd;
        end else begin
          e_if_pulse = 1; e_if_rdata = rd;
        end
      end
      next_cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, address width of all ports.
REQ-002 Parameter DATA_W, default 64, data width; wmask width is DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 if_req_valid  input  1  fetch requester has a read request.
REQ-006 if_req_ready  output  1  fetch request accepted this cycle.
REQ-007 if_addr  input  ADDR_W  fetch read address.
REQ-008 if_resp_valid  output  1  one-cycle pulse; if_rdata valid.
REQ-009 if_rdata  output  DATA_W  fetch read data.
REQ-010 ls_req_valid  input  1  load/store requester has a request.
REQ-011 ls_req_ready  output  1  load/store request accepted this cycle.
REQ-012 ls_addr  input  ADDR_W  load/store address.
REQ-013 ls_wen  input  1  1 = store, 0 = load.
REQ-014 ls_wdata  input  DATA_W  store data.
REQ-015 ls_wmask  input  DATA_W/8  store byte mask.
REQ-016 ls_resp_valid  output  1  one-cycle pulse; load data or store completion.
REQ-017 ls_rdata  output  DATA_W  load data; zero for stores.
REQ-018 mem_req_valid  output  1  request to the shared memory port.
REQ-019 mem_req_ready  input  1  memory port accepts request.
REQ-020 mem_addr / mem_wen / mem_wdata / mem_wmask  output  ADDR_W / 1 / DATA_W / DATA_W/8  latched request fields.
REQ-021 mem_resp_valid  input  1  memory response present; mem_rdata  input  DATA_W  response data.

Function
REQ-022 FSM states IDLE, REQ, WAIT; one outstanding transaction at most.
REQ-023 IDLE: the granted requester's req_ready is 1 combinationally when its valid is 1; the other's is 0; both 0 outside IDLE.
REQ-024 Accept (valid&&ready in IDLE): latch addr, wen, wdata, wmask (wen=0, wdata=0, wmask=0 for fetch) and owner; next state REQ.
REQ-025 REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready -> WAIT; otherwise stay.
REQ-026 WAIT: on mem_resp_valid, register mem_rdata into owner's rdata, pulse owner's resp_valid for exactly one cycle next cycle, -> IDLE.
REQ-027 Minimum latency accept-edge to resp_valid: 3 cycles (ready and response each on first cycle); new accept possible the cycle resp_valid is high.
REQ-028 Stores produce ls_resp_valid with ls_rdata=0; mem_rdata ignored.
REQ-029 mem_req_ready outside REQ and mem_resp_valid outside WAIT are ignored.
REQ-030 Fixed priority (default): both valid in IDLE -> LSU granted.
REQ-031 Non-owner rdata and resp_valid remain unchanged/0 during a transaction.

Reset
REQ-032 rst_n low, at any time including mid-transaction: state=IDLE, outstanding transaction dropped, all outputs and latched fields 0, round-robin pointer = "last grant IF".
REQ-033 First acceptance possible in the first cycle after rst_n deasserts.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: round-robin; both valid -> grant requester not granted last; pointer updates on every accept.
REQ-035 MEM_ARB_RR_EN undefined: fixed priority per REQ-030; no pointer register.

Structure
REQ-036 Package mem_arb_pkg holds state enum (IDLE/REQ/WAIT), owner enum (OWN_IF/OWN_LS), default ADDR_W/DATA_W constants.
REQ-037 One sub-module mem_arb_grant: combinational grant from two valids plus pointer, containing the MEM_ARB_RR_EN selection.

Verification
REQ-038 Fetch 0x80000000, mem_req_ready=1, response 0x00100073_00000413 next cycle -> if_resp_valid 1 cycle, if_rdata matches, 3-cycle latency.
REQ-039 Store addr 0x80001000, wdata 0x8765432112345678, wmask 0x03, mem_req_ready held 0 for 4 cycles -> mem fields stable all 5 cycles, ls_resp_valid with ls_rdata=0.
REQ-040 Both valid continuously for 4 transactions -> fixed: LS,LS,LS,LS; MEM_ARB_RR_EN: LS,IF,LS,IF.
REQ-041 rst_n low during WAIT, then mem_resp_valid -> no resp_valid pulse, state IDLE, outputs 0.
REQ-042 Spurious mem_resp_valid in IDLE and mem_req_ready in WAIT -> no state change, no response pulses.
